// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a five-stage pipeline with a multicycle
//   multiply/divide unit in E. It resolves three situations:
//     * load-use: the load in E feeds a source register in D, so F and D
//       hold while E takes a bubble;
//     * mispredict: the branch in E resolved wrong, so D and E are squashed;
//     * multicycle op: a multiply/divide holds F/D/E and feeds M with NOPs
//       until its final (DONE) cycle.
//   All stall/bubble outputs are combinational from the FSM state and the
//   current inputs.
//
// Parameters
//   MUL_CYCLES  multiply occupancy in E, 2..63 (default 4)
//   DIV_CYCLES  divide occupancy in E, 2..63 (default 32)
//   RNONE       register id that means "no register" (mirrors def.v)
//
// Ports
//   clk                         pipeline clock, rising edge
//   rst_n                       asynchronous active-low reset
//   d_srcA, d_srcB              decode-stage source registers
//   E_dstM                      load destination of the instruction in E
//   e_mispred                   branch in E mispredicted this cycle
//   E_mdStart, E_mdDiv          multiply/divide start request, 1 = divide
//   F_stall, D_stall, E_stall   hold the named pipeline register
//   W_stall                     reserved, always 0
//   D_bubble, E_bubble, M_bubble load a NOP into the named pipeline register
//   md_busy                     multicycle unit occupying E (stall cycles)
//   md_done                     final-cycle strobe of a multicycle op
//
// Optional feature
//   `define PIPE_HAZARD_PERF_EN adds two 32-bit wrapping counters:
//   perf_stall_cnt (cycles with F_stall) and perf_bubble_cnt (cycles with
//   D_bubble or E_bubble). Without the macro those ports do not exist.
module pipe_hazard_ctrl #(
  parameter int         MUL_CYCLES = 4,
  parameter int         DIV_CYCLES = 32,
  parameter logic [4:0] RNONE      = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  d_srcA,
  input  logic [4:0]  d_srcB,
  input  logic [4:0]  E_dstM,
  input  logic        e_mispred,
  input  logic        E_mdStart,
  input  logic        E_mdDiv,
  output logic        F_stall,
  output logic        D_stall,
  output logic        E_stall,
  output logic        W_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        md_busy,
  output logic        md_done
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The start cycle (in IDLE) and the DONE cycle account for two of the N+1
  // occupancy cycles, so BUSY runs N-1 cycles: counter loads N-2 and BUSY
  // exits when it reaches zero.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt;
  logic [5:0] cnt_nxt;

  logic start_ok;
  logic load_use;

  // A start is only honoured out of reset and when the same instruction is
  // not being squashed by a mispredict.
  assign start_ok = rst_n && E_mdStart && !e_mispred;

  // RNONE on a source never matches, even against an RNONE load target.
  assign load_use = (E_dstM != RNONE) &&
                    (((d_srcA != RNONE) && (d_srcA == E_dstM)) ||
                     ((d_srcB != RNONE) && (d_srcB == E_dstM)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = BUSY;
          cnt_nxt   = E_mdDiv ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt != 6'd0) begin
          cnt_nxt = cnt - 6'd1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  // Output priority: multicycle occupancy > mispredict > load-use.
  always_comb begin
    md_busy  = ((state == IDLE) && start_ok) || (state == BUSY);
    md_done  = (state == DONE);
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (md_busy) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_bubble = 1'b1;
    end else if (e_mispred) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
    end else if (load_use) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (F_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (D_bubble || E_bubble) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of single-cycle hazard vectors,
// hand-written multicycle sequences (multiply, divide under load-use,
// back-to-back gap, reset abort), randomized stimulus against a cycle-count
// reference model, and the optional performance counters when
// PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int         MUL_N = 4;
  localparam int         DIV_N = 32;
  localparam logic [4:0] RN    = 5'd31;

  // Output vector order: {F,D,E_stall,W,D_bub,E_bub,M_bub,busy,done}
  localparam logic [8:0] V_IDLE = 9'b000000000;
  localparam logic [8:0] V_LU   = 9'b110001000;
  localparam logic [8:0] V_MISP = 9'b000011000;
  localparam logic [8:0] V_BUSY = 9'b111000110;
  localparam logic [8:0] V_DONE = 9'b000000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] d_srcA, d_srcB, E_dstM;
  logic       e_mispred, E_mdStart, E_mdDiv;
  logic       F_stall, D_stall, E_stall, W_stall;
  logic       D_bubble, E_bubble, M_bubble;
  logic       md_busy, md_done;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  pipe_hazard_ctrl #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .RNONE     (RN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_dstM   (E_dstM),
    .e_mispred(e_mispred),
    .E_mdStart(E_mdStart),
    .E_mdDiv  (E_mdDiv),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .E_stall  (E_stall),
    .W_stall  (W_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .md_busy  (md_busy),
    .md_done  (md_done)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: occ = -1 when no operation is in flight, otherwise the
  // number of cycles elapsed since the accepted start (1..len-1 stall cycles,
  // len is the final cycle).
  int occ = -1;
  int len = 0;

  logic [8:0] dut_v;
  assign dut_v = {F_stall, D_stall, E_stall, W_stall, D_bubble, E_bubble,
                  M_bubble, md_busy, md_done};

  function automatic logic [8:0] model_out();
    logic busy, done, lu;
    logic [8:0] v;
    busy = (occ < 0 && E_mdStart && !e_mispred && rst_n) ||
           (occ >= 1 && occ < len);
    done = (occ >= 1 && occ == len);
    lu   = (E_dstM != RN) &&
           ((d_srcA == E_dstM && d_srcA != RN) ||
            (d_srcB == E_dstM && d_srcB != RN));
    if (busy)           v = V_BUSY;
    else if (e_mispred) v = V_MISP;
    else if (lu)        v = V_LU;
    else                v = V_IDLE;
    v[0] = done;
    return v;
  endfunction

  task automatic model_adv();
    if (!rst_n) begin
      occ = -1;
    end else if (occ < 0) begin
      if (E_mdStart && !e_mispred) begin
        occ = 1;
        len = E_mdDiv ? DIV_N : MUL_N;
      end
    end else if (occ < len) begin
      occ = occ + 1;
    end else begin
      occ = -1;
    end
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    n_cmp++;
    if (dut_v !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, dut_v, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] m, input logic mis,
                       input logic st, input logic dv);
    d_srcA = a; d_srcB = b; E_dstM = m;
    e_mispred = mis; E_mdStart = st; E_mdDiv = dv;
  endtask

  // One clock: inputs already driven just after the rising edge; outputs
  // compared on the falling edge; model advanced on the next rising edge.
  task automatic cyc(input string name, input logic [8:0] exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic cyc_model(input string name);
    logic [8:0] exp;
    @(negedge clk);
    exp = model_out();
    check(name, exp);
    @(posedge clk);
    model_adv();
    #1;
  endtask

  typedef struct {
    logic [4:0] a, b, m;
    logic       mis, st, dv;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{a:RN,    b:RN,    m:RN,    mis:0, st:0, dv:0, exp:V_IDLE};
    tbl[1] = '{a:RN,    b:5'd5,  m:5'd5,  mis:0, st:0, dv:0, exp:V_LU};
    tbl[2] = '{a:5'd5,  b:RN,    m:5'd5,  mis:0, st:0, dv:0, exp:V_LU};
    tbl[3] = '{a:5'd5,  b:RN,    m:5'd5,  mis:1, st:0, dv:0, exp:V_MISP};
    tbl[4] = '{a:5'd1,  b:5'd2,  m:RN,    mis:1, st:0, dv:0, exp:V_MISP};
    tbl[5] = '{a:RN,    b:5'd3,  m:RN,    mis:0, st:0, dv:0, exp:V_IDLE};
    tbl[6] = '{a:5'd6,  b:5'd4,  m:5'd5,  mis:0, st:0, dv:0, exp:V_IDLE};
    tbl[7] = '{a:RN,    b:RN,    m:RN,    mis:1, st:1, dv:1, exp:V_MISP};
    tbl[8] = '{a:5'd0,  b:RN,    m:5'd0,  mis:0, st:0, dv:0, exp:V_LU};
    tbl[9] = '{a:5'd9,  b:5'd9,  m:5'd9,  mis:0, st:0, dv:0, exp:V_LU};

    // Reset state
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", V_IDLE);
    @(posedge clk);
    model_adv();
    #1;
    rst_n = 1'b1;

    // Single-cycle hazard table (each entry starts from IDLE)
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].mis, tbl[i].st, tbl[i].dv);
      cyc($sformatf("table_%0d", i), tbl[i].exp);
    end
    // Start suppressed by the mispredict in entry 7 must leave the unit idle
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    cyc("idle_after_table", V_IDLE);

    // Multiply: busy cycles 0-3, done at 4 with start still held (not
    // accepted), then re-accepted the cycle after DONE.
    drive(RN, RN, RN, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc($sformatf("mul_busy_c%0d", c), V_BUSY);
    cyc("mul_done_c4", V_DONE);
    for (int c = 0; c < 4; c++) cyc($sformatf("mul2_busy_c%0d", c), V_BUSY);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    cyc("mul2_done", V_DONE);
    cyc("mul2_idle", V_IDLE);

    // Divide under a load-use hazard: only the md pattern while busy, then
    // the load-use rule reappears in DONE.
    drive(5'd7, RN, 5'd7, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 32; c++) cyc($sformatf("div_busy_c%0d", c), V_BUSY);
    cyc("div_done_lu", V_LU | V_DONE);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    cyc("div_idle", V_IDLE);

    // Reset in cycle 10 of a divide aborts it
    drive(RN, RN, RN, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) cyc($sformatf("rdiv_busy_c%0d", c), V_BUSY);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    occ = -1;
    #1;
    check("reset_mid_div", V_IDLE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(RN, RN, RN, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc($sformatf("post_rst_busy_c%0d", c), V_BUSY);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    cyc("post_rst_done", V_DONE);
    cyc("post_rst_idle", V_IDLE);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ra, rb, rm;
      ra = ($urandom_range(0, 3) == 0) ? RN : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? RN : 5'($urandom_range(0, 7));
      rm = ($urandom_range(0, 3) == 0) ? RN : 5'($urandom_range(0, 7));
      drive(ra, rb, rm, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      cyc_model("random");
    end

`ifdef PIPE_HAZARD_PERF_EN
    // One multiply plus one mispredict
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    occ = -1;
    #1;
    n_cmp++;
    if (perf_stall_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0",
               perf_stall_cnt, perf_bubble_cnt);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(RN, RN, RN, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cyc("perf_mul_busy", V_BUSY);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    cyc("perf_mul_done", V_DONE);
    drive(RN, RN, RN, 1'b1, 1'b0, 1'b0);
    cyc("perf_misp", V_MISP);
    drive(RN, RN, RN, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (perf_stall_cnt !== 32'd4 || perf_bubble_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL perf_counts: got %0d/%0d want 4/1",
               perf_stall_cnt, perf_bubble_cnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
